imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory: receives a program as a byte stream over a valid/ready handshake and writes it into instruction memory as 32-bit little-endian words at byte addresses 0, 4, 8, …
- Holds the CPU in reset (`cpu_hold`) until the image is fully written, then releases it.
- Sits between the boot/debug byte source and the instruction memory write port.

Parameters:
- INSTR_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).
- ADDRESS_WIDTH, 32, width of the write byte-address bus.
- LENGTH, 64, instruction memory capacity in words; the maximum accepted image size.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  single-cycle pulse; aborts any load and returns the block to IDLE.
- byte_valid  in  1  source presents a byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDRESS_WIDTH  byte address of the write; always a multiple of 4.
- wr_data  out  INSTR_WIDTH  assembled instruction word.
- cpu_hold  out  1  high = CPU held in reset.
- load_done  out  1  image fully written.
- load_error  out  1  image rejected.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0, load_done=0, load_error=0, cpu_hold=1, byte_ready=0.
  - Byte counters and word counters cleared.
- Handshake:
  - A byte transfers on a rising edge where byte_valid && byte_ready.
  - byte_ready is decoded from state: high only in LEN_LO, LEN_HI, DATA and CSUM.
- Stream format:
  - Header: word count N, 16 bits, little-endian (LEN_LO byte, then LEN_HI byte).
  - Body: N words, 4 bytes each, LSB first.
- States and transitions:
  - IDLE: go to LEN_LO on the next clock.
  - LEN_LO: on a transfer, latch N[7:0], go to LEN_HI.
  - LEN_HI: on a transfer, latch N[15:8].
    - If N > LENGTH → ERROR.
    - If N = 0 → DONE (CSUM if the option is on).
    - Otherwise → DATA.
  - DATA: shift in bytes; on the 4th byte → WRITE.
  - WRITE: one cycle, byte_ready=0.
    - wr_en=1, wr_addr = word_index*4, wr_data = assembled word.
    - word_index increments.
    - If word_index+1 == N → DONE (CSUM if the option is on); else → DATA.
  - DONE: load_done=1, cpu_hold=0; held until restart.
  - ERROR: load_error=1, cpu_hold=1; held until restart.
- Outputs wr_en, wr_addr and wr_data are registered:
  - 4th byte accepted at edge k → wr_en high between edges k and k+1.
  - wr_en is low in every other cycle.
  - wr_addr and wr_data hold their last values when wr_en=0.
- restart:
  - Highest priority in all states: next state IDLE.
  - Clears load_done, load_error, counters and partial word; sets cpu_hold=1.
  - Memory contents already written are not erased.
- byte_valid while byte_ready=0 is not a transfer; the source must hold the byte.
- wr_addr width: word_index*4 is truncated to ADDRESS_WIDTH. LENGTH ≤ 2^(ADDRESS_WIDTH-2), so no wrap occurs.
- cpu_hold changes only on DONE entry, restart, or reset.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE (or after the header when N=0) the block enters CSUM and accepts one byte.
  - If that byte equals the XOR of all body bytes (0x00 when N=0) → DONE; else → ERROR.
  - Words are already written either way; cpu_hold stays 1 on mismatch.
- Undefined: no CSUM state; the block goes directly to DONE after the last word.

Test Plan:
- Reset, then send 02 00 13 00 00 00 93 00 10 00:
  - wr_en pulses twice: (addr 0x0, data 0x00000013), then (addr 0x4, data 0x00100093).
  - Then load_done=1, cpu_hold=0.
- Header 41 00 with LENGTH=64 → ERROR: load_error=1, cpu_hold=1, byte_ready=0, no wr_en. Then a restart pulse → load_error=0 and the block accepts a new header.
- Header 00 00 → load_done=1 with zero writes (option off).
- Back-pressure: byte_valid held high continuously for a 3-word image:
  - byte_ready drops for exactly one cycle after every 4th byte.
  - No byte lost or duplicated; words land at 0x0, 0x4, 0x8.
- Assert rst_n=0 mid-word (after 2 body bytes):
  - All outputs return to reset values immediately.
  - A full reload then writes the correct words with no residue from the partial word.
- With IMEM_LOADER_CHECKSUM_EN, image 01 00 13 00 00 00:
  - Checksum byte 13 → DONE.
  - Checksum byte 12 → ERROR, cpu_hold stays 1.

Source files
------------

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of imem_loader
interface imem_loader_if #(
    parameter int INSTR_WIDTH   = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     byte_valid;
    logic [7:0]               byte_data;
    logic                     byte_ready;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [INSTR_WIDTH-1:0]   wr_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte stream into instruction memory, holds CPU until done
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int INSTR_WIDTH   = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LENGTH        = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_error
);
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    localparam logic [15:0] LEN_MAX = 16'(LENGTH);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] part;
    logic [15:0] hdr_len;
    logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    always_comb begin
        bus.byte_ready = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA: bus.byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:                 bus.byte_ready = 1'b1;
`endif
            default:              bus.byte_ready = 1'b0;
        endcase
    end

    assign xfer    = bus.byte_valid && bus.byte_ready;
    assign hdr_len = {bus.byte_data, len_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            cpu_hold    <= 1'b1;
            len_lo      <= '0;
            n_words     <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            part        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else if (restart) begin
            // Abort wins over everything; already-written memory is left as is.
            state      <= IDLE;
            bus.wr_en  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cpu_hold   <= 1'b1;
            len_lo     <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            part       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= LEN_LO;
                    word_idx <= '0;
                    byte_cnt <= '0;
                    part     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum     <= '0;
`endif
                end
                LEN_LO: if (xfer) begin
                    len_lo <= bus.byte_data;
                    state  <= LEN_HI;
                end
                LEN_HI: if (xfer) begin
                    n_words <= hdr_len;
                    if (hdr_len > LEN_MAX) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (hdr_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state     <= CSUM;
`else
                        state     <= DONE;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum <= csum ^ bus.byte_data;
`endif
                    byte_cnt <= byte_cnt + 2'd1;
                    // Bytes arrive LSB first, so each new byte enters at the top of the shifter.
                    if (byte_cnt == 2'd3) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= ADDRESS_WIDTH'({word_idx, 2'b00});
                        bus.wr_data <= INSTR_WIDTH'({bus.byte_data, part});
                        state       <= WRITE;
                    end else begin
                        part <= {bus.byte_data, part[23:8]};
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    if (word_idx + 16'd1 == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state     <= CSUM;
`else
                        state     <= DONE;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: if (xfer) begin
                    if (bus.byte_data == csum) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end else begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end
                end
`endif
                DONE, ERROR: state <= state;
                default:     state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed cycle-table and sequence checks for imem_loader
module tb_imem_loader;
    logic clk;
    logic rst_n;
    logic restart;
    logic cpu_hold, load_done, load_error;
    int   n_chk  = 0;
    int   n_fail = 0;

    imem_loader_if #(.INSTR_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    imem_loader #(.INSTR_WIDTH(32), .ADDRESS_WIDTH(32), .LENGTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle: inputs driven during the cycle, outputs expected in it.
    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        rs;
        logic        rdy;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        err;
        logic        hold;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic v, logic [7:0] d, logic rs, logic rdy, logic wen,
                                logic [31:0] addr, logic [31:0] data, logic done, logic err, logic hold);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.rs = rs; r.rdy = rdy; r.wen = wen;
        r.addr = addr; r.data = data; r.done = done; r.err = err; r.hold = hold;
        return r;
    endfunction

    task automatic add(logic rst, logic v, logic [7:0] d, logic rs, logic rdy, logic wen,
                       logic [31:0] addr, logic [31:0] data, logic done, logic err, logic hold);
        vq.push_back(mk(rst, v, d, rs, rdy, wen, addr, data, done, err, hold));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input vec_t e);
        chk({name, "/byte_ready"}, 32'(bus.byte_ready), 32'(e.rdy));
        chk({name, "/wr_en"},      32'(bus.wr_en),      32'(e.wen));
        chk({name, "/wr_addr"},    bus.wr_addr,         e.addr);
        chk({name, "/wr_data"},    bus.wr_data,         e.data);
        chk({name, "/load_done"},  32'(load_done),      32'(e.done));
        chk({name, "/load_error"}, 32'(load_error),     32'(e.err));
        chk({name, "/cpu_hold"},   32'(cpu_hold),       32'(e.hold));
    endtask

    // Entered and left at posedge+1.
    task automatic step(input vec_t e, input string name);
        bus.byte_valid = e.v;
        bus.byte_data  = e.d;
        restart        = e.rs;
        @(negedge clk);
        check_outs(name, e);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs are checked before any clock edge can act.
    task automatic do_reset(input string name);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        restart        = 1'b0;
        rst_n          = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        check_outs(name, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Closes an image whose last WRITE cycle has just been stepped.
    task automatic finish_image(input logic [7:0] cs, input logic [31:0] la, input logic [31:0] ld,
                                input string name);
`ifdef IMEM_LOADER_CHECKSUM_EN
        step(mk(0, 1, cs, 0, 1, 0, la, ld, 0, 0, 1), {name, "_csum"});
`else
        if (cs != 8'hxx) bus.byte_data = cs;
`endif
        step(mk(0, 0, 8'h00, 0, 0, 0, la, ld, 1, 0, 0), {name, "_done"});
    endtask

    logic [31:0] bp_words [3];
    logic [31:0] la, ld;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        restart        = 1'b0;
        rst_n          = 1'b0;

`ifndef IMEM_LOADER_CHECKSUM_EN
        // Two-word image, source keeps byte_valid high across the WRITE cycle.
        add(1, 1, 8'h02, 0, 0, 0, 32'h0, 32'h0,        0, 0, 1);
        add(0, 1, 8'h02, 0, 1, 0, 32'h0, 32'h0,        0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0,        0, 0, 1);
        add(0, 1, 8'h13, 0, 1, 0, 32'h0, 32'h0,        0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0,        0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0,        0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0,        0, 0, 1);
        add(0, 1, 8'h93, 0, 0, 1, 32'h0, 32'h13,       0, 0, 1);
        add(0, 1, 8'h93, 0, 1, 0, 32'h0, 32'h13,       0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h13,       0, 0, 1);
        add(0, 1, 8'h10, 0, 1, 0, 32'h0, 32'h13,       0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h13,       0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 1, 32'h4, 32'h00100093, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 32'h4, 32'h00100093, 1, 0, 0);
        add(0, 1, 8'h55, 0, 0, 0, 32'h4, 32'h00100093, 1, 0, 0);
        // Oversize header 0x0041, restart, then empty image 00 00, restart from DONE.
        add(1, 1, 8'h41, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 1, 8'h41, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 1, 8'h13, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1);
        add(0, 1, 8'h13, 1, 0, 0, 32'h0, 32'h0, 0, 1, 1);
        add(0, 1, 8'h00, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
`endif
        // Header exactly LENGTH (0x0040) is accepted, then aborted.
        add(1, 1, 8'h40, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 1, 8'h40, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);

        foreach (vq[i]) begin
            if (vq[i].rst) do_reset($sformatf("vec%0d_reset", i));
            step(vq[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: byte_valid never drops over a 3-word image of bytes 01..0c.
        bp_words[0] = 32'h04030201;
        bp_words[1] = 32'h08070605;
        bp_words[2] = 32'h0c0b0a09;
        do_reset("bp_reset");
        step(mk(0, 1, 8'h03, 0, 0, 0, 0, 0, 0, 0, 1), "bp_idle");
        step(mk(0, 1, 8'h03, 0, 1, 0, 0, 0, 0, 0, 1), "bp_len_lo");
        step(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1), "bp_len_hi");
        la = 32'h0;
        ld = 32'h0;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++)
                step(mk(0, 1, 8'(w * 4 + b + 1), 0, 1, 0, la, ld, 0, 0, 1), $sformatf("bp_w%0d_b%0d", w, b));
            step(mk(0, 1, 8'(w * 4 + 5), 0, 0, 1, 32'(w * 4), bp_words[w], 0, 0, 1), $sformatf("bp_w%0d_write", w));
            la = 32'(w * 4);
            ld = bp_words[w];
        end
        finish_image(8'h0c, la, ld, "bp");

        // Reset mid-word after one full word plus two bytes, then a clean one-word reload.
        do_reset("mw_reset0");
        step(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1), "mw_idle");
        step(mk(0, 1, 8'h02, 0, 1, 0, 0, 0, 0, 0, 1), "mw_len_lo");
        step(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1), "mw_len_hi");
        step(mk(0, 1, 8'h78, 0, 1, 0, 0, 0, 0, 0, 1), "mw_b0");
        step(mk(0, 1, 8'h56, 0, 1, 0, 0, 0, 0, 0, 1), "mw_b1");
        step(mk(0, 1, 8'h34, 0, 1, 0, 0, 0, 0, 0, 1), "mw_b2");
        step(mk(0, 1, 8'h12, 0, 1, 0, 0, 0, 0, 0, 1), "mw_b3");
        step(mk(0, 0, 8'h00, 0, 0, 1, 32'h0, 32'h12345678, 0, 0, 1), "mw_write0");
        step(mk(0, 1, 8'hef, 0, 1, 0, 32'h0, 32'h12345678, 0, 0, 1), "mw_b4");
        step(mk(0, 1, 8'hbe, 0, 1, 0, 32'h0, 32'h12345678, 0, 0, 1), "mw_b5");
        do_reset("mw_async_reset");
        step(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1), "rl_idle");
        step(mk(0, 1, 8'h01, 0, 1, 0, 0, 0, 0, 0, 1), "rl_len_lo");
        step(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1), "rl_len_hi");
        step(mk(0, 1, 8'haa, 0, 1, 0, 0, 0, 0, 0, 1), "rl_b0");
        step(mk(0, 1, 8'hbb, 0, 1, 0, 0, 0, 0, 0, 1), "rl_b1");
        step(mk(0, 1, 8'hcc, 0, 1, 0, 0, 0, 0, 0, 1), "rl_b2");
        step(mk(0, 1, 8'hdd, 0, 1, 0, 0, 0, 0, 0, 1), "rl_b3");
        step(mk(0, 0, 8'h00, 0, 0, 1, 32'h0, 32'hddccbbaa, 0, 0, 1), "rl_write");
        finish_image(8'h00, 32'h0, 32'hddccbbaa, "rl");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Image 01 00 13 00 00 00: checksum 13 is good, 12 is rejected.
        for (int k = 0; k < 2; k++) begin
            do_reset($sformatf("cs%0d_reset", k));
            step(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("cs%0d_idle", k));
            step(mk(0, 1, 8'h01, 0, 1, 0, 0, 0, 0, 0, 1), $sformatf("cs%0d_len_lo", k));
            step(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1), $sformatf("cs%0d_len_hi", k));
            step(mk(0, 1, 8'h13, 0, 1, 0, 0, 0, 0, 0, 1), $sformatf("cs%0d_b0", k));
            step(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1), $sformatf("cs%0d_b1", k));
            step(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1), $sformatf("cs%0d_b2", k));
            step(mk(0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1), $sformatf("cs%0d_b3", k));
            step(mk(0, 0, 8'h00, 0, 0, 1, 32'h0, 32'h13, 0, 0, 1), $sformatf("cs%0d_write", k));
            step(mk(0, 1, (k == 0) ? 8'h13 : 8'h12, 0, 1, 0, 32'h0, 32'h13, 0, 0, 1), $sformatf("cs%0d_csum", k));
            if (k == 0)
                step(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 32'h13, 1, 0, 0), "cs0_done");
            else
                step(mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 32'h13, 0, 1, 1), "cs1_error");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
